sum_capture_fifo: RTL and testbench
===================================

Name: sum_capture_fifo

Overview:
- Downstream consumer of the pipelined adding machine's 32-bit running-sum output.
- Captures sum values into a small circular FIFO and drains them to a slower consumer (display or host reader) over a valid/ready handshake.
- Optionally suppresses consecutive duplicate samples.
- Counts samples dropped while full, so the producer never has to stall.

Parameters:
- WIDTH, 32: data width of captured sums.
- DEPTH, 4: number of FIFO entries; must be a power of two, minimum 2.
- PTR_W, 2: log2(DEPTH), width of read/write pointers.
- DROP_W, 16: width of the saturating drop counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  sum value from the adding machine.
- in_valid  input  1  in_data is a candidate sample this cycle.
- dedup_en  input  1  when 1, a sample equal to the last accepted sample is not pushed.
- out_data  output  WIDTH  entry at the FIFO head.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- full  output  1  count == DEPTH.
- count  output  PTR_W+1  number of stored entries, 0..DEPTH.
- drop_count  output  DROP_W  samples lost because the FIFO was full; saturates at all-ones.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately, independent of clk) clears:
  - rd_ptr, wr_ptr, count and drop_count to 0;
  - all storage entries to 0;
  - last_accepted to 0 and have_last to 0.
  - Outputs during/after reset: out_valid=0, full=0, count=0, drop_count=0, out_data=0.
- Reset mid-operation discards all stored entries; no partial state survives.
- Candidate sample: in_valid=1 AND NOT (dedup_en=1 AND have_last=1 AND in_data==last_accepted).
- Pop: out_valid=1 AND out_ready=1. out_ready while empty is ignored.
- Push: candidate AND (count<DEPTH OR pop this cycle).
  - Data written to mem[wr_ptr]; wr_ptr increments modulo DEPTH (natural wrap of PTR_W bits).
- Drop: candidate AND count==DEPTH AND no pop this cycle.
  - drop_count increments by 1 unless already all-ones, where it holds.
- Dedup reference state:
  - On every push, last_accepted<=in_data and have_last<=1.
  - On a drop, last_accepted and have_last are unchanged.
  - A cycle where the sample is suppressed by dedup is neither a push nor a drop.
- Pop advances rd_ptr modulo DEPTH.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged.
  - neither: unchanged.
- Simultaneous push and pop when full is legal: the head is consumed and the new sample is written into the freed slot in the same edge; no drop.
- Simultaneous push and pop when count==1:
  - the old head pops;
  - the new entry becomes head next cycle;
  - out_valid stays 1.
- No fall-through: data pushed into an empty FIFO appears on out_data/out_valid one cycle after the push edge. Write-to-read latency is 1 cycle.
- out_data = mem[rd_ptr] combinationally; its value is don't-care while out_valid=0, but it must be stable for a held entry.
- out_valid = (count!=0) and full = (count==DEPTH), both combinational from registered count.
- dedup_en may change any cycle; it affects only the current cycle's candidate decision.

Test Plan:
- Reset, then assert in_valid for 1 cycle with in_data=0x00000005, out_ready=0 -> next cycle out_valid=1, out_data=5, count=1; with reset asserted mid-cycle -> count=0, out_valid=0 immediately, without waiting for a clock edge.
- Push 1,3,6,10 (out_ready=0), then push 15 and 21 -> full=1, count=4, drop_count=2; then hold out_ready=1 -> drains 1,3,6,10 in order, then out_valid=0.
- Full FIFO holding 1,3,6,10, with in_valid=1 in_data=15 and out_ready=1 in the same cycle -> no drop, count stays 4, subsequent drain order 3,6,10,15.
- dedup_en=1, in_valid=1 for 4 cycles with in_data=7,7,7,9 -> count=2, contents 7,9; dedup_en=0 with in_data=9 -> count=3.
- Continuous push/pop stream of 10 values with out_ready=1 from cycle 0 -> out_data sequence matches input delayed 1 cycle, count never exceeds 1, pointers wrap past DEPTH without corruption.
- Force drop_count near saturation by 65540 drop cycles while full -> drop_count=0xFFFF and holds.

Source files
------------

// File: rtl/sum_capture_fifo.sv
// Capture FIFO for the adding machine's running-sum output: optional
// duplicate suppression, valid/ready drain, and a saturating drop counter.
module sum_capture_fifo #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = 2,
    parameter int unsigned DROP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    input  logic              dedup_en,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              full,
    output logic [PTR_W:0]    count,
    output logic [DROP_W-1:0] drop_count
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [WIDTH-1:0]  last_q, last_d;
    logic              have_last_q, have_last_d;

    logic is_dup, cand, pop, push, drop, is_full;

    always_comb begin
        is_dup  = dedup_en && have_last_q && (in_data == last_q);
        cand    = in_valid && !is_dup;
        pop     = (count_q != '0) && out_ready;
        is_full = (count_q == DEPTH_C);
        // A pop frees the head slot on the same edge, so a full FIFO can still accept.
        push    = cand && (!is_full || pop);
        drop    = cand && is_full && !pop;

        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        last_d      = push ? in_data : last_q;
        have_last_d = push ? 1'b1    : have_last_q;

        count_d = count_q;
        if (push && !pop)
            count_d = count_q + (PTR_W+1)'(1);
        else if (pop && !push)
            count_d = count_q - (PTR_W+1)'(1);

        drop_d = drop_q;
        if (drop && (drop_q != '1))
            drop_d = drop_q + DROP_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            drop_q      <= '0;
            last_q      <= '0;
            have_last_q <= 1'b0;
        end else begin
            if (push)
                mem_q[wr_ptr_q] <= in_data;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
            last_q      <= last_d;
            have_last_q <= have_last_d;
        end
    end

    assign out_data   = mem_q[rd_ptr_q];
    assign out_valid  = (count_q != '0);
    assign full       = (count_q == DEPTH_C);
    assign count      = count_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_sum_capture_fifo.sv
// Randomized and directed bench for sum_capture_fifo against a queue-based model.
module tb_sum_capture_fifo;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;
    localparam int DROP_W = 16;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_valid = 1'b0;
    logic              dedup_en = 1'b0;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              full;
    logic [PTR_W:0]    count;
    logic [DROP_W-1:0] drop_count;

    sum_capture_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W), .DROP_W(DROP_W)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .dedup_en(dedup_en), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .full(full), .count(count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: a plain queue plus the dedup reference and drop tally.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_last;
    bit               m_have_last;
    int               m_drops;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_last = '0;
        m_have_last = 0;
        m_drops = 0;
    endtask

    task automatic check_outputs();
        check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        check("count", 64'(count), 64'(mq.size()));
        check("full", 64'(full), 64'(mq.size() == DEPTH));
        check("drop_count", 64'(drop_count), 64'(m_drops));
        if (mq.size() != 0)
            check("out_data", 64'(out_data), 64'(mq[0]));
    endtask

    task automatic model_cycle(input logic v, input logic [WIDTH-1:0] d,
                               input logic de, input logic r);
        bit cand, pop, was_full;
        cand = v && !(de && m_have_last && d == m_last);
        pop = (mq.size() != 0) && r;
        was_full = (mq.size() == DEPTH);
        if (pop) void'(mq.pop_front());
        if (cand) begin
            if (!was_full || pop) begin
                mq.push_back(d);
                m_last = d;
                m_have_last = 1;
            end else if (m_drops < DROP_MAX) begin
                m_drops++;
            end
        end
    endtask

    // Drive one cycle: check registered outputs, then apply inputs across the next edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d,
                        input logic de, input logic r);
        @(negedge clk);
        in_valid = v;
        in_data = d;
        dedup_en = de;
        out_ready = r;
        check_outputs();
        model_cycle(v, d, de, r);
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push_list(input logic [WIDTH-1:0] vals[$]);
        foreach (vals[i]) step(1'b1, vals[i], 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        do_reset();

        // Single push, then an asynchronous reset between edges.
        step(1'b1, 32'h5, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_data", 64'(out_data), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Overflow with drops, then ordered drain.
        push_list('{32'd1, 32'd3, 32'd6, 32'd10, 32'd15, 32'd21});
        drain(6);

        // Simultaneous push and pop while full.
        do_reset();
        push_list('{32'd1, 32'd3, 32'd6, 32'd10});
        step(1'b1, 32'd15, 1'b0, 1'b1);
        drain(5);

        // Dedup on, then off.
        do_reset();
        step(1'b1, 32'd7, 1'b1, 1'b0);
        step(1'b1, 32'd7, 1'b1, 1'b0);
        step(1'b1, 32'd7, 1'b1, 1'b0);
        step(1'b1, 32'd9, 1'b1, 1'b0);
        step(1'b1, 32'd9, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        check("dedup_count", 64'(count), 64'd3);
        drain(4);

        // Streaming push/pop with pointer wrap.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b1);
        drain(2);

        // Random traffic; small data range makes dedup hits likely.
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 5)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
        drain(5);

        // Drop counter saturation.
        do_reset();
        push_list('{32'd1, 32'd2, 32'd3, 32'd4});
        for (int i = 0; i < 65540; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        check("drop_sat", 64'(drop_count), 64'hFFFF);
        step(1'b1, 32'd99, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        check("drop_hold", 64'(drop_count), 64'hFFFF);
        drain(5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
